// File: rtl/bit_packer.sv
// Packs variable-length input chunks into fixed OUT_W words, LSB- or MSB-first.
// Latency: an accepted chunk is visible in count/out_valid/out_data after the same edge.
// Backpressure: in_ready drops when fewer than IN_W free bits remain or a flush is pending.
module bit_packer #(
    parameter  int IN_W  = 64,
    parameter  int OUT_W = 24,
    parameter  int DEPTH = 128,
    localparam int LW    = $clog2(IN_W + 1),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msb_first,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LW-1:0]    in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             err
);

    generate
        if (DEPTH < IN_W + OUT_W) begin : g_depth_chk
            $error("bit_packer: DEPTH must be >= IN_W + OUT_W");
        end
    endgenerate

    // bits_q holds the stream in arrival order: bit 0 is the oldest buffered bit,
    // and every position at or above count is kept zero so tail padding is free.
    logic [DEPTH-1:0] bits_q, bits_base, bits_next;
    logic [CW-1:0]    cnt_base, cnt_next;
    logic             order_q, flush_pend;
    logic             ord_in, len_ok, acc, full, drain;
    logic [IN_W-1:0]  rev, seq, len_mask;
    logic [OUT_W-1:0] word, word_rev;

    always_comb begin
        len_ok   = (in_len != '0) && (in_len <= LW'(IN_W));
        in_ready = rst && (count <= CW'(DEPTH - IN_W)) && !flush_pend;
        acc      = in_valid && in_ready;
        // The first chunk after empty decides the order for everything that follows.
        ord_in   = (count == '0) ? msb_first : order_q;

        rev = '0;
        for (int i = 0; i < IN_W; i++) begin
            rev[i] = in_data[IN_W-1-i];
        end
        len_mask = {IN_W{1'b1}} >> (LW'(IN_W) - in_len);
        seq      = (ord_in ? (rev >> (LW'(IN_W) - in_len)) : in_data) & len_mask;

        full      = count >= CW'(OUT_W);
        out_valid = full || (flush_pend && (count != '0));
        drain     = out_valid && out_ready;

        word     = bits_q[OUT_W-1:0];
        word_rev = '0;
        for (int i = 0; i < OUT_W; i++) begin
            word_rev[i] = word[OUT_W-1-i];
        end
        out_data = '0;
        if (out_valid) begin
            out_data = order_q ? word_rev : word;
        end

        bits_base = bits_q;
        cnt_base  = count;
        if (drain && full) begin
            bits_base = bits_q >> OUT_W;
            cnt_base  = count - CW'(OUT_W);
        end else if (drain) begin
            bits_base = '0;
            cnt_base  = '0;
        end

        bits_next = bits_base;
        cnt_next  = cnt_base;
        if (acc && len_ok) begin
            bits_next = bits_base | (DEPTH'(seq) << cnt_base);
            cnt_next  = cnt_base + CW'(in_len);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q     <= '0;
            count      <= '0;
            order_q    <= 1'b0;
            flush_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            bits_q     <= bits_next;
            count      <= cnt_next;
            flush_pend <= flush || (flush_pend && (cnt_next != '0));
            if (acc && (count == '0)) begin
                order_q <= msb_first;
            end
            if (acc && !len_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer (IN_W=8, OUT_W=12, DEPTH=24) with a queue scoreboard
// fed by the stimulus and drained by an independent output monitor.
module tb_bit_packer;
    localparam int IN_W  = 8;
    localparam int OUT_W = 12;
    localparam int DEPTH = 24;
    localparam int LW    = $clog2(IN_W + 1);
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             msb_first;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [LW-1:0]    in_len;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             flush;
    logic [CW-1:0]    count;
    logic             err;

    int checks = 0;
    int passes = 0;
    logic [OUT_W-1:0] exp_q[$];

    bit_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .msb_first (msb_first),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every word the DUT hands over is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
            end else begin
                check("out_data", {20'd0, out_data}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [3:0] l);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL push_timeout: in_ready 0, expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        msb_first = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        flush     = 1'b0;

        #2;
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // LSB-first 0xAB, 0xCD -> 0xDAB, 4 bits left; flush pads them.
        push(8'hAB, 4'd8);
        check("lsb_count8", count, 8);
        check("lsb_idle_valid", out_valid, 0);
        check("lsb_idle_data", out_data, 0);
        exp_q.push_back(12'hDAB);
        push(8'hCD, 4'd8);
        check("lsb_count16", count, 16);
        step();
        check("lsb_count4", count, 4);
        exp_q.push_back(12'h00C);
        flush_pulse();
        check("flush_blocks_in", in_ready, 0);
        step();
        check("lsb_flush_count", count, 0);
        check("lsb_flush_in_ready", in_ready, 1);

        // msb_first toggled mid-stream must not change the order.
        push(8'hAB, 4'd8);
        msb_first = 1'b1;
        exp_q.push_back(12'hDAB);
        push(8'hCD, 4'd8);
        step();
        check("order_hold_count", count, 4);
        exp_q.push_back(12'h00C);
        flush_pulse();
        step();
        check("order_hold_flush", count, 0);

        // MSB-first 0xAB, 0xCD -> 0xABC, then padded tail 0xD00.
        exp_q.push_back(12'hABC);
        push(8'hAB, 4'd8);
        push(8'hCD, 4'd8);
        step();
        check("msb_count4", count, 4);
        exp_q.push_back(12'hD00);
        flush_pulse();
        step();
        check("msb_flush_count", count, 0);
        check("msb_flush_in_ready", in_ready, 1);

        // Four 3-bit chunks fill exactly one word.
        msb_first = 1'b0;
        exp_q.push_back(12'hB6D);
        for (int i = 0; i < 4; i++) begin
            push(8'h05, 4'd3);
        end
        check("len3_count12", count, 12);
        step();
        check("len3_count0", count, 0);

        // Fill to DEPTH with the consumer stalled, then drain one word at a time.
        out_ready = 1'b0;
        push(8'h11, 4'd8);
        push(8'h22, 4'd8);
        push(8'h33, 4'd8);
        check("full_count", count, 24);
        check("full_in_ready", in_ready, 0);
        exp_q.push_back(12'h211);
        exp_q.push_back(12'h332);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain1_count", count, 12);
        check("drain1_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("drain2_count", count, 0);

        // Illegal lengths are handshaken, dropped and latch err.
        push(8'hFF, 4'd0);
        check("len0_count", count, 0);
        check("len0_err", err, 1);
        push(8'hFF, 4'd9);
        check("len9_count", count, 0);
        check("len9_err", err, 1);
        exp_q.push_back(12'h0AB);
        push(8'hAB, 4'd8);
        check("err_sticky", err, 1);
        check("legal_after_err_count", count, 8);
        flush_pulse();
        step();
        check("err_flush_count", count, 0);

        // Asynchronous reset mid-operation with 20 bits buffered and a flush pending.
        out_ready = 1'b0;
        push(8'h11, 4'd8);
        push(8'h22, 4'd8);
        push(8'h03, 4'd4);
        check("pre_rst_count", count, 20);
        flush_pulse();
        check("pre_rst_valid", out_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_err", err, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rerst_in_ready", in_ready, 1);
        step();
        check("rerst_count", count, 0);
        check("rerst_in_ready_edge", in_ready, 1);
        check("rerst_out_valid", out_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
